wb_data_ram: RTL and testbench

WB_DATA_RAM -- requirements
Module: wb_data_ram

---
 rtl/wb_data_ram_if.sv | 25 ++
 rtl/wb_data_ram.sv | 166 ++++++++++++++++
 tb/tb_wb_data_ram.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_data_ram_if.sv
// Wishbone classic slave bus bundle for wb_data_ram.
// The master drives requests and the slave returns registered responses.
interface wb_data_ram_if #(
    parameter int DATA_W = 32
);
    logic                  wb_cyc_i;
    logic                  wb_stb_i;
    logic                  wb_we_i;
    logic [31:0]           wb_addr_i;
    logic [DATA_W-1:0]     wb_dat_i;
    logic [DATA_W/8-1:0]   wb_sel_i;
    logic [DATA_W-1:0]     wb_dat_o;
    logic                  wb_ack_o;
    logic                  wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_data_ram.sv
// Wishbone data RAM with byte-lane writes, optional wait states and
// range/alignment error termination.
module wb_data_ram #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic           wb_clk,
    input  logic           wb_rst_n,
    wb_data_ram_if.slave   bus
);
    localparam int          NB         = DATA_W / 8;
    localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          LSB        = (NB > 1) ? $clog2(NB) : 0;
    localparam logic [32:0] SPAN       = 33'(DEPTH * NB);
    localparam logic [31:0] ALIGN_MASK = 32'(NB - 1);
    localparam logic [3:0]  WS         = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [NB-1:0]     sel_q, sel_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_s;
    logic              commit_s;
    logic              op_we_s;
    logic [31:0]       op_addr_s;
    logic [DATA_W-1:0] op_dat_s;
    logic [NB-1:0]     op_sel_s;
    logic [31:0]       offset_s;
    logic [IDX_W-1:0]  idx_s;
    logic              addr_err_s;

    // Operand select: with no wait states the access completes on the accept edge itself.
    always_comb begin
        req_s = bus.wb_cyc_i & bus.wb_stb_i;
        if (state_q == ST_IDLE) begin
            op_we_s   = bus.wb_we_i;
            op_addr_s = bus.wb_addr_i;
            op_dat_s  = bus.wb_dat_i;
            op_sel_s  = bus.wb_sel_i;
        end else begin
            op_we_s   = we_q;
            op_addr_s = addr_q;
            op_dat_s  = dat_q;
            op_sel_s  = sel_q;
        end
        offset_s   = op_addr_s - BASE_ADDR;
        idx_s      = offset_s[LSB +: IDX_W];
        addr_err_s = ({1'b0, offset_s} >= SPAN) || ((offset_s & ALIGN_MASK) != 32'd0);
    end

    // Next-state, wait counter and request capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    we_d   = bus.wb_we_i;
                    addr_d = bus.wb_addr_i;
                    dat_d  = bus.wb_dat_i;
                    sel_d  = bus.wb_sel_i;
                    if (WS == 4'd0) begin
                        state_d  = ST_RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!bus.wb_cyc_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d  = ST_RESP;
                    cnt_d    = 4'd0;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response strobes and read data, all loaded on the edge entering RESP.
    always_comb begin
        ack_d = commit_s & ~addr_err_s;
        err_d = commit_s & addr_err_s;
        if (commit_s && !addr_err_s && !op_we_s) begin
            rdat_d = mem[idx_s];
        end else begin
            rdat_d = rdat_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            dat_q   <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    // Byte-lane write; storage keeps its contents across reset.
    always_ff @(posedge wb_clk) begin
        if (wb_rst_n && commit_s && op_we_s && !addr_err_s) begin
            for (int b = 0; b < NB; b++) begin
                if (op_sel_s[b]) begin
                    mem[idx_s][8*b +: 8] <= op_dat_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.wb_ack_o = ack_q;
    assign bus.wb_err_o = err_q;
    assign bus.wb_dat_o = rdat_q;
endmodule

// File: tb/tb_wb_data_ram.sv
// Directed bench for wb_data_ram: three instances (no wait / 3 waits with
// offset base / 2 waits for reset) checked each cycle against a transaction model.
module tb_wb_data_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        rst_n;
    logic [2:0]        cyc, stb, we;
    logic [2:0][31:0]  addr, wdat;
    logic [2:0][3:0]   sel;
    logic [2:0]        ack_o, err_o;
    logic [2:0][31:0]  dat_o;

    int n_pass  = 0;
    int n_total = 0;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 1) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_data_ram_if #(.DATA_W(32)) bus_if ();
        assign bus_if.wb_cyc_i  = cyc[g];
        assign bus_if.wb_stb_i  = stb[g];
        assign bus_if.wb_we_i   = we[g];
        assign bus_if.wb_addr_i = addr[g];
        assign bus_if.wb_dat_i  = wdat[g];
        assign bus_if.wb_sel_i  = sel[g];
        assign ack_o[g]         = bus_if.wb_ack_o;
        assign err_o[g]         = bus_if.wb_err_o;
        assign dat_o[g]         = bus_if.wb_dat_o;
        wb_data_ram #(
            .DATA_W(32), .DEPTH(1024),
            .WAIT_STATES(ws_of(g)), .BASE_ADDR(base_of(g))
        ) u_dut (
            .wb_clk(clk), .wb_rst_n(rst_n[g]), .bus(bus_if)
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Transaction model: a request taken at edge e is answered in the cycle after edge e+ws.
    logic [31:0]      mmem [3][1024];
    logic [2:0]       m_ack, m_err;
    logic [2:0][31:0] m_dat;
    bit               pend [3];
    bit               blk  [3];
    int               due  [3];
    logic             t_we [3];
    logic [31:0]      t_addr [3];
    logic [31:0]      t_dat  [3];
    logic [3:0]       t_sel  [3];
    int               ecount = 0;

    task automatic model_apply(input int d);
        logic [31:0] off;
        off = t_addr[d] - base_of(d);
        if (off >= 32'd4096 || off[1:0] != 2'd0) begin
            m_err[d] = 1'b1;
        end else if (t_we[d]) begin
            for (int b = 0; b < 4; b++)
                if (t_sel[d][b]) mmem[d][off >> 2][8*b +: 8] = t_dat[d][8*b +: 8];
            m_ack[d] = 1'b1;
        end else begin
            m_dat[d] = mmem[d][off >> 2];
            m_ack[d] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        bit fire;
        ecount++;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n[d]) begin
                pend[d] = 1'b0; blk[d] = 1'b0;
                m_ack[d] = 1'b0; m_err[d] = 1'b0; m_dat[d] = 32'd0;
            end else begin
                m_ack[d] = 1'b0; m_err[d] = 1'b0; fire = 1'b0;
                if (pend[d]) begin
                    if (!cyc[d]) pend[d] = 1'b0;
                    else if (ecount == due[d]) begin pend[d] = 1'b0; fire = 1'b1; end
                end else if (!blk[d] && cyc[d] && stb[d]) begin
                    t_we[d] = we[d]; t_addr[d] = addr[d]; t_dat[d] = wdat[d]; t_sel[d] = sel[d];
                    due[d] = ecount + ws_of(d);
                    if (ws_of(d) == 0) fire = 1'b1;
                    else pend[d] = 1'b1;
                end
                blk[d] = fire;
                if (fire) model_apply(d);
            end
        end
        #2;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("ack[%0d]@%0d", d, ecount), 32'(ack_o[d]), 32'(m_ack[d]));
            chk($sformatf("err[%0d]@%0d", d, ecount), 32'(err_o[d]), 32'(m_err[d]));
            chk($sformatf("dat[%0d]@%0d", d, ecount), dat_o[d], m_dat[d]);
        end
    end

    // One transfer on an idle instance; records ack/err for each cycle after acceptance.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dt,
                        input logic [3:0] s, output logic [7:0] ah, output logic [7:0] eh);
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; wdat[d] = dt; sel[d] = s;
        @(negedge clk);
        stb[d] = 1'b0;
        ah = 8'd0; eh = 8'd0;
        ah[0] = ack_o[d]; eh[0] = err_o[d];
        for (int i = 1; i <= ws_of(d); i++) begin
            @(negedge clk);
            ah[i] = ack_o[d]; eh[i] = err_o[d];
        end
        cyc[d] = 1'b0; we[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] ah, eh;
        logic [4:0] pat;
        logic       seen;
        rst_n = 3'b000; cyc = '0; stb = '0; we = '0; addr = '0; wdat = '0; sel = '0;
        repeat (3) @(negedge clk);
        chk("reset_ack", 32'(ack_o), 32'd0);
        chk("reset_dat0", dat_o[0], 32'd0);
        rst_n = 3'b111;

        // No wait states: full write, readback, byte lanes, empty sel.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ah, eh);
        chk("w0_ack_hist", 32'(ah), 32'h01);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, ah, eh);
        chk("r0_ack_hist", 32'(ah), 32'h01);
        chk("r0_data", dat_o[0], 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, ah, eh);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, ah, eh);
        chk("lanes_data", dat_o[0], 32'hDE22BE44);
        chk("model_pin_lanes", mmem[0][4], 32'hDE22BE44);
        xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, ah, eh);
        chk("sel0_ack_hist", 32'(ah), 32'h01);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, ah, eh);
        chk("sel0_data", dat_o[0], 32'hDE22BE44);
        xfer(0, 1'b1, 32'h20, 32'hA0A0A0A0, 4'hF, ah, eh);
        xfer(0, 1'b1, 32'h24, 32'hB1B1B1B1, 4'hF, ah, eh);

        // Back-to-back reads with strobe held high.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        @(negedge clk); pat[0] = ack_o[0]; chk("b2b_d0", dat_o[0], 32'hDE22BE44); addr[0] = 32'h20;
        @(negedge clk); pat[1] = ack_o[0];
        @(negedge clk); pat[2] = ack_o[0]; chk("b2b_d1", dat_o[0], 32'hA0A0A0A0); addr[0] = 32'h24;
        @(negedge clk); pat[3] = ack_o[0];
        @(negedge clk); pat[4] = ack_o[0]; chk("b2b_d2", dat_o[0], 32'hB1B1B1B1);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        chk("b2b_pattern", 32'(pat), 32'h15);

        // Three wait states, base 0x1000.
        xfer(1, 1'b1, 32'h1004, 32'hCAFE1234, 4'hF, ah, eh);
        chk("ws3_w_hist", 32'(ah), 32'h08);
        xfer(1, 1'b0, 32'h1004, 32'h0, 4'h0, ah, eh);
        chk("ws3_r_hist", 32'(ah), 32'h08);
        chk("ws3_r_data", dat_o[1], 32'hCAFE1234);

        // Abort a write by dropping cyc two cycles after acceptance.
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h1004; wdat[1] = 32'h55555555; sel[1] = 4'hF;
        @(negedge clk); stb[1] = 1'b0;
        @(negedge clk); cyc[1] = 1'b0; we[1] = 1'b0;
        seen = 1'b0;
        repeat (5) begin @(negedge clk); seen = seen | ack_o[1] | err_o[1]; end
        chk("abort_no_resp", 32'(seen), 32'd0);
        xfer(1, 1'b0, 32'h1004, 32'h0, 4'h0, ah, eh);
        chk("abort_mem_kept", dat_o[1], 32'hCAFE1234);

        // Error terminations and the last valid word.
        xfer(1, 1'b1, 32'h2000, 32'h12121212, 4'hF, ah, eh);
        chk("err_range_err", 32'(eh), 32'h08);
        chk("err_range_ack", 32'(ah), 32'h00);
        xfer(1, 1'b0, 32'h1002, 32'h0, 4'h0, ah, eh);
        chk("err_misalign", 32'(eh), 32'h08);
        chk("err_dat_kept", dat_o[1], 32'hCAFE1234);
        xfer(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, ah, eh);
        chk("err_wrap", 32'(eh), 32'h08);
        xfer(1, 1'b1, 32'h1FFC, 32'h600DF00D, 4'hF, ah, eh);
        chk("last_word_ack", 32'(ah), 32'h08);
        xfer(1, 1'b0, 32'h1FFC, 32'h0, 4'h0, ah, eh);
        chk("last_word_data", dat_o[1], 32'h600DF00D);
        chk("model_pin_last", mmem[1][1023], 32'h600DF00D);

        // Two wait states: reset during WAIT discards the write.
        xfer(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, ah, eh);
        xfer(2, 1'b1, 32'h24, 32'h12345678, 4'hF, ah, eh);
        xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, ah, eh);
        chk("ws2_r_hist", 32'(ah), 32'h04);
        chk("ws2_r_data", dat_o[2], 32'hCAFEF00D);
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdat[2] = 32'h0BADBEEF; sel[2] = 4'hF;
        @(negedge clk); stb[2] = 1'b0;
        #1 rst_n[2] = 1'b0; cyc[2] = 1'b0; we[2] = 1'b0;
        #1;
        chk("rst_async_ack", 32'(ack_o[2]), 32'd0);
        chk("rst_async_err", 32'(err_o[2]), 32'd0);
        chk("rst_async_dat", dat_o[2], 32'd0);
        repeat (3) @(negedge clk);
        rst_n[2] = 1'b1;
        xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, ah, eh);
        chk("rst_word_kept", dat_o[2], 32'hCAFEF00D);
        xfer(2, 1'b0, 32'h24, 32'h0, 4'h0, ah, eh);
        chk("rst_other_word", dat_o[2], 32'h12345678);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
